// File: rtl/operand_loader_if.sv
// Operand loader bus: raw buttons, switch nibble, ack in; operands and status out.
interface operand_loader_if;
    logic       pb1;
    logic       pb2;
    logic       pb3;
    logic       pb4;
    logic [3:0] y;
    logic       ack;
    logic [6:0] a;
    logic [6:0] b;
    logic [3:0] loaded;
    logic       valid;
    logic       err;

    modport master (
        output pb1, pb2, pb3, pb4, y, ack,
        input  a, b, loaded, valid, err
    );

    modport slave (
        input  pb1, pb2, pb3, pb4, y, ack,
        output a, b, loaded, valid, err
    );
endinterface

// File: rtl/operand_loader.sv
// Debounced button front-end loading two 7-bit operands from a switch nibble.
// Define ORDER_CHECK_EN to enforce ALO->AHI->BLO->BHI load order with sticky err.
module operand_loader #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    operand_loader_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       pb_raw;
    logic [3:0]       pb_s1;
    logic [3:0]       pb_s2;
    logic [3:0]       y_s1;
    logic [3:0]       ys;
    logic [3:0]       db;
    logic [3:0]       db_d;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       press;
    logic [3:0]       acc;
    logic [6:0]       a_q;
    logic [6:0]       b_q;
    logic [3:0]       loaded;
    logic             valid;
    logic             err;
    logic             accept;

    assign pb_raw = {bus.pb4, bus.pb3, bus.pb2, bus.pb1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_s1 <= '0;
            pb_s2 <= '0;
            y_s1  <= '0;
            ys    <= '0;
        end else begin
            pb_s1 <= pb_raw;
            pb_s2 <= pb_s1;
            y_s1  <= bus.y;
            ys    <= y_s1;
        end
    end

    // State flips only after DB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < 4; i++) begin
                if (pb_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press  = db & ~db_d;
    assign accept = valid & bus.ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (acc[0]) a_q[3:0] <= ys;
            if (acc[1]) a_q[6:4] <= ys[2:0];
            if (acc[2]) b_q[3:0] <= ys;
            if (acc[3]) b_q[6:4] <= ys[2:0];
        end
    end

`ifdef ORDER_CHECK_EN
    typedef enum logic [2:0] {
        WAIT_ALO,
        WAIT_AHI,
        WAIT_BLO,
        WAIT_BHI,
        FULL
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] want;
    logic       bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_ALO;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_ALO: if (acc[0]) state_nx = WAIT_AHI;
            WAIT_AHI: if (acc[1]) state_nx = WAIT_BLO;
            WAIT_BLO: if (acc[2]) state_nx = WAIT_BHI;
            WAIT_BHI: if (acc[3]) state_nx = FULL;
            FULL:     if (bus.ack) state_nx = WAIT_ALO;
            default:  state_nx = WAIT_ALO;
        endcase
    end

    always_comb begin
        want   = 4'b0000;
        loaded = 4'b0000;
        valid  = 1'b0;
        unique case (state)
            WAIT_ALO: want = 4'b0001;
            WAIT_AHI: begin
                want   = 4'b0010;
                loaded = 4'b0001;
            end
            WAIT_BLO: begin
                want   = 4'b0100;
                loaded = 4'b0011;
            end
            WAIT_BHI: begin
                want   = 4'b1000;
                loaded = 4'b0111;
            end
            FULL: begin
                loaded = 4'b1111;
                valid  = 1'b1;
            end
            default: ;
        endcase
    end

    assign acc = press & want;
    assign bad = |(press & ~want);

    // Accepting the operands clears the violation history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         err <= 1'b0;
        else if (accept) err <= 1'b0;
        else if (bad)    err <= 1'b1;
    end
`else
    assign acc = press;
    assign err = 1'b0;

    // A press coinciding with accept keeps its own flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loaded <= '0;
            valid  <= 1'b0;
        end else if (accept) begin
            loaded <= acc;
            valid  <= 1'b0;
        end else begin
            loaded <= loaded | acc;
            valid  <= &loaded;
        end
    end
`endif

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.loaded = loaded;
    assign bus.valid  = valid;
    assign bus.err    = err;
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DB_CYCLES=4 (press-to-capture = 7 cycles).
// Covers reset, glitch rejection, load latency, handshake and optional order check.
module tb_operand_loader;
    logic       clk;
    logic       rst;
    logic [3:0] pb;
    logic [3:0] yv;
    logic       ack;
    int         checks;
    int         errors;

    operand_loader_if bus ();

    assign bus.pb1 = pb[0];
    assign bus.pb2 = pb[1];
    assign bus.pb3 = pb[2];
    assign bus.pb4 = pb[3];
    assign bus.y   = yv;
    assign bus.ack = ack;

    operand_loader #(
        .DB_CYCLES (4),
        .CNT_W     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise a button; returns one cycle before its capture edge.
    task automatic press_start(input int btn, input logic [3:0] val);
        yv      = val;
        pb[btn] = 1'b1;
        tick(6);
    endtask

    task automatic press_end(input int btn);
        tick(3);
        pb[btn] = 1'b0;
        tick(10);
    endtask

    task automatic load(input int btn, input logic [3:0] val);
        press_start(btn, val);
        tick(1);
        press_end(btn);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        pb     = 4'b0000;
        yv     = 4'h0;
        ack    = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("rst_a", {1'b0, bus.a}, 8'h00);
        chk("rst_b", {1'b0, bus.b}, 8'h00);
        chk("rst_loaded", {4'h0, bus.loaded}, 8'h00);
        chk("rst_valid", {7'h0, bus.valid}, 8'h00);
        chk("rst_err", {7'h0, bus.err}, 8'h00);

        yv    = 4'h1;
        pb[0] = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        chk("midrst_a", {1'b0, bus.a}, 8'h00);
        chk("midrst_loaded", {4'h0, bus.loaded}, 8'h00);
        pb[0] = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(15);
        chk("postrst_a", {1'b0, bus.a}, 8'h00);
        chk("postrst_loaded", {4'h0, bus.loaded}, 8'h00);

        yv    = 4'hA;
        pb[0] = 1'b1;
        tick(2);
        pb[0] = 1'b0;
        tick(12);
        chk("glitch_a", {1'b0, bus.a}, 8'h00);
        chk("glitch_loaded", {4'h0, bus.loaded}, 8'h00);

`ifdef ORDER_CHECK_EN
        load(2, 4'h9);
        chk("ord_bad_b", {1'b0, bus.b}, 8'h00);
        chk("ord_bad_err", {7'h0, bus.err}, 8'h01);
        chk("ord_bad_loaded", {4'h0, bus.loaded}, 8'h00);
        load(0, 4'h5);
        chk("ord_l1", {4'h0, bus.loaded}, 8'h01);
        load(1, 4'h3);
        load(2, 4'h9);
        chk("ord_l3", {4'h0, bus.loaded}, 8'h07);
        load(3, 4'h6);
        chk("ord_valid", {7'h0, bus.valid}, 8'h01);
        chk("ord_err_held", {7'h0, bus.err}, 8'h01);
        chk("ord_a", {1'b0, bus.a}, 8'h35);
        chk("ord_b", {1'b0, bus.b}, 8'h69);
        load(0, 4'h1);
        chk("ord_full_a", {1'b0, bus.a}, 8'h35);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ord_ack_err", {7'h0, bus.err}, 8'h00);
        chk("ord_ack_valid", {7'h0, bus.valid}, 8'h00);
        chk("ord_ack_loaded", {4'h0, bus.loaded}, 8'h00);
        load(0, 4'h1);
        chk("ord_restart_a", {1'b0, bus.a}, 8'h31);
        chk("ord_restart_l", {4'h0, bus.loaded}, 8'h01);
`else
        press_start(0, 4'h5);
        chk("lat1_pre", {1'b0, bus.a}, 8'h00);
        tick(1);
        chk("lat1_a", {1'b0, bus.a}, 8'h05);
        chk("lat1_l", {4'h0, bus.loaded}, 8'h01);
        press_end(0);

        press_start(1, 4'h3);
        chk("lat2_pre", {1'b0, bus.a}, 8'h05);
        tick(1);
        chk("lat2_a", {1'b0, bus.a}, 8'h35);
        chk("lat2_l", {4'h0, bus.loaded}, 8'h03);
        press_end(1);

        press_start(2, 4'h9);
        chk("lat3_pre", {1'b0, bus.b}, 8'h00);
        tick(1);
        chk("lat3_b", {1'b0, bus.b}, 8'h09);
        press_end(2);

        press_start(3, 4'h6);
        chk("lat4_pre", {1'b0, bus.b}, 8'h09);
        chk("lat4_pre_l", {4'h0, bus.loaded}, 8'h07);
        tick(1);
        chk("lat4_b", {1'b0, bus.b}, 8'h69);
        chk("lat4_l", {4'h0, bus.loaded}, 8'h0F);
        chk("lat4_novalid", {7'h0, bus.valid}, 8'h00);
        tick(1);
        chk("valid_rise", {7'h0, bus.valid}, 8'h01);
        chk("err_tied", {7'h0, bus.err}, 8'h00);
        press_end(3);

        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ack_valid", {7'h0, bus.valid}, 8'h00);
        chk("ack_loaded", {4'h0, bus.loaded}, 8'h00);
        chk("ack_a", {1'b0, bus.a}, 8'h35);
        chk("ack_b", {1'b0, bus.b}, 8'h69);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(1);
        chk("ack2_valid", {7'h0, bus.valid}, 8'h00);
        chk("ack2_loaded", {4'h0, bus.loaded}, 8'h00);
        chk("ack2_a", {1'b0, bus.a}, 8'h35);

        load(0, 4'h5);
        load(1, 4'h3);
        load(2, 4'h9);
        load(3, 4'h6);
        chk("reload_valid", {7'h0, bus.valid}, 8'h01);
        load(3, 4'hF);
        chk("ovw_b", {1'b0, bus.b}, 8'h79);
        chk("ovw_valid", {7'h0, bus.valid}, 8'h01);
        chk("ovw_loaded", {4'h0, bus.loaded}, 8'h0F);

        press_start(2, 4'h2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("coll_loaded", {4'h0, bus.loaded}, 8'h04);
        chk("coll_valid", {7'h0, bus.valid}, 8'h00);
        chk("coll_b", {1'b0, bus.b}, 8'h72);
        chk("coll_a", {1'b0, bus.a}, 8'h35);
        tick(1);
        chk("coll_valid2", {7'h0, bus.valid}, 8'h00);
        press_end(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
